// File: rtl/halflife_timer_core.sv
// Loadable up/down counter with a timed decay mode that halves the value every PERIOD enabled cycles.
// Optional halving counter output enabled by defining HL_HALVINGS_EN.
module halflife_timer_core #(
   parameter int WIDTH    = 4,
   parameter int PERIOD   = 4,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   input  logic             down,
   input  logic             decay_start,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
`ifdef HL_HALVINGS_EN
   ,
   output logic [7:0]       halvings
`endif
);

   localparam int PW = $clog2(PERIOD + 1);
   localparam logic [PW-1:0]    PRE_LAST = PW'(PERIOD - 1);
   localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DECAY = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state;
   logic [PW-1:0]   pre;
   logic [WIDTH-1:0] count_inc;
   logic [WIDTH-1:0] count_dec;
   logic [WIDTH-1:0] count_half;

   always_comb begin
      count_inc  = (SATURATE && count == MAX_VAL) ? count : count + WIDTH'(1);
      count_dec  = (SATURATE && count == '0) ? count : count - WIDTH'(1);
      count_half = count >> 1;
   end

`ifdef HL_HALVINGS_EN
   logic [7:0] halv_cnt;
   assign halvings = halv_cnt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         pre   <= '0;
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef HL_HALVINGS_EN
         halv_cnt <= 8'd0;
`endif
      end else if (load) begin
         // load wins in every state and silently aborts a running decay
         count <= load_val;
         pre   <= '0;
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (decay_start) begin
                  pre <= '0;
`ifdef HL_HALVINGS_EN
                  halv_cnt <= 8'd0;
`endif
                  if (count != '0) begin
                     state <= DECAY;
                     busy  <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end else if (en && up && !down) begin
                  count <= count_inc;
               end else if (en && down && !up) begin
                  count <= count_dec;
               end
            end
            DECAY: begin
               if (en) begin
                  if (pre == PRE_LAST) begin
                     pre   <= '0;
                     count <= count_half;
`ifdef HL_HALVINGS_EN
                     if (halv_cnt != 8'hFF) halv_cnt <= halv_cnt + 8'd1;
`endif
                     if (count_half == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     pre <= pre + PW'(1);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_halflife_timer_core.sv
// Directed bench for halflife_timer_core: saturating instance plus a wrapping instance on shared stimulus.
module tb_halflife_timer_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       load;
   logic [3:0] load_val;
   logic       up;
   logic       down;
   logic       decay_start;
   logic [3:0] count;
   logic       busy;
   logic       done;
   logic [3:0] count_w;
   logic       busy_w;
   logic       done_w;
`ifdef HL_HALVINGS_EN
   logic [7:0] halvings;
   logic [7:0] halvings_w;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int done_seen;
   logic [3:0] exp_count;

   always #5 clk = ~clk;

   halflife_timer_core #(.WIDTH(4), .PERIOD(4), .SATURATE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
      .up(up), .down(down), .decay_start(decay_start),
      .count(count), .busy(busy), .done(done)
`ifdef HL_HALVINGS_EN
      , .halvings(halvings)
`endif
   );

   halflife_timer_core #(.WIDTH(4), .PERIOD(4), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
      .up(up), .down(down), .decay_start(decay_start),
      .count(count_w), .busy(busy_w), .done(done_w)
`ifdef HL_HALVINGS_EN
      , .halvings(halvings_w)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; load = 1'b0; load_val = 4'd0;
      up = 1'b0; down = 1'b0; decay_start = 1'b0;
      #3;
      chk("reset_count", count, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_count_wrap", count_w, 0);
`ifdef HL_HALVINGS_EN
      chk("reset_halvings", halvings, 0);
`endif
      step();
      rst_n = 1'b1;

      // decay from 12: 6,3,1,0 at +4,+8,+12,+16
      load = 1'b1; load_val = 4'd12; step(); load = 1'b0;
      chk("t1_load", count, 12);
      decay_start = 1'b1; step(); decay_start = 1'b0;
      chk("t1_busy_start", busy, 1);
      chk("t1_count_start", count, 12);
      done_seen = 0;
      for (int i = 1; i <= 16; i++) begin
         step();
         exp_count = (i < 4) ? 4'd12 : (i < 8) ? 4'd6 : (i < 12) ? 4'd3 : (i < 16) ? 4'd1 : 4'd0;
         chk($sformatf("t1_count_%0d", i), count, exp_count);
         chk($sformatf("t1_busy_%0d", i), busy, (i < 16) ? 1 : 0);
         if (done) done_seen++;
      end
      chk("t1_done_at_16", done, 1);
      step();
      if (done) done_seen++;
      chk("t1_done_once", done_seen, 1);
      chk("t1_busy_after", busy, 0);
`ifdef HL_HALVINGS_EN
      chk("t1_halvings", halvings, 4);
`endif

      // saturation vs wrap at both ends
      load = 1'b1; load_val = 4'd14; step(); load = 1'b0;
      up = 1'b1;
      step(); chk("t2_up1", count, 15); chk("t2_up1_wrap", count_w, 15);
      step(); chk("t2_up2", count, 15); chk("t2_up2_wrap", count_w, 0);
      step(); chk("t2_up3", count, 15); chk("t2_up3_wrap", count_w, 1);
      down = 1'b1;
      step(); chk("t2_updown_hold", count, 15); chk("t2_updown_hold_wrap", count_w, 1);
      up = 1'b0; down = 1'b0;
      load = 1'b1; load_val = 4'd1; step(); load = 1'b0;
      down = 1'b1;
      step(); chk("t2_down1", count, 0); chk("t2_down1_wrap", count_w, 0);
      step(); chk("t2_down2", count, 0); chk("t2_down2_wrap", count_w, 15);
      down = 1'b0;

      // en low for 3 cycles mid-period delays the halving by 3
      load = 1'b1; load_val = 4'd8; step(); load = 1'b0;
      decay_start = 1'b1; step(); decay_start = 1'b0;
      step(); step();
      chk("t3_pre_freeze", count, 8);
      en = 1'b0;
      step(); step(); step();
      chk("t3_frozen", count, 8);
      chk("t3_frozen_busy", busy, 1);
      en = 1'b1;
      step(); chk("t3_not_yet", count, 8);
      step(); chk("t3_half1", count, 4);
      repeat (3) step();
      chk("t3_hold4", count, 4);
      step(); chk("t3_half2", count, 2);
      repeat (4) step(); chk("t3_half3", count, 1);
      repeat (4) step(); chk("t3_zero", count, 0);
      chk("t3_done", done, 1);
      step(); chk("t3_done_clear", done, 0);

      // load mid-decay aborts with no done pulse
      load = 1'b1; load_val = 4'd9; step(); load = 1'b0;
      decay_start = 1'b1; step(); decay_start = 1'b0;
      repeat (5) step();
      chk("t4_mid_count", count, 4);
      load = 1'b1; load_val = 4'd5; step(); load = 1'b0;
      chk("t4_load_count", count, 5);
      chk("t4_load_busy", busy, 0);
      chk("t4_load_done", done, 0);
      up = 1'b1; step(); up = 1'b0;
      chk("t4_up_after", count, 6);
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done || busy) done_seen++;
      end
      chk("t4_no_done", done_seen, 0);
      chk("t4_count_held", count, 6);

      // decay_start from zero: immediate done, never busy
      load = 1'b1; load_val = 4'd0; step(); load = 1'b0;
      decay_start = 1'b1; step(); decay_start = 1'b0;
      chk("t5_done", done, 1);
      chk("t5_busy", busy, 0);
      chk("t5_count", count, 0);
      step();
      chk("t5_done_clear", done, 0);
      chk("t5_busy_after", busy, 0);
      chk("t5_count_after", count, 0);

      // asynchronous reset between edges during decay
      load = 1'b1; load_val = 4'd12; step(); load = 1'b0;
      decay_start = 1'b1; step(); decay_start = 1'b0;
      repeat (5) step();
      chk("t6_pre_reset", count, 6);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_count", count, 0);
      chk("t6_async_busy", busy, 0);
      step();
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done || busy) done_seen++;
      end
      chk("t6_no_done", done_seen, 0);
      chk("t6_count_zero", count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
